// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 8-digit 7-segment display.
// Takes one snapshot of the 64-bit dot vector per frame and blanks each digit slot briefly at its start.
module seg7_scan_driver #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [15:0] BLANK_CYCLES = 16'd500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] seg7_dot64,
    input  logic        hold,
    input  logic        blank,
    output logic [7:0]  an_n,
    output logic [7:0]  seg_n,
    output logic        frame_tick
);

    if (SCAN_DIV < 16'd2 || BLANK_CYCLES < 16'd1 || BLANK_CYCLES > SCAN_DIV - 16'd1) begin : g_param_check
        $error("seg7_scan_driver: need SCAN_DIV >= 2 and 1 <= BLANK_CYCLES <= SCAN_DIV-1");
    end

    logic [15:0] r_cnt;
    logic [2:0]  r_digit;
    logic [63:0] r_snap;
    logic [7:0]  r_an_n;
    logic [7:0]  r_seg_n;
    logic        r_frame_tick;

    logic        w_slot_end;
    logic        w_boundary;
    logic        w_guard;
    logic [7:0]  w_byte;
    logic [7:0]  w_an_on;

    always_comb begin
        w_slot_end = (r_cnt == SCAN_DIV - 16'd1);
        w_boundary = (r_digit == 3'd0) && (r_cnt == 16'd0);
        w_guard    = (r_cnt < BLANK_CYCLES);
        w_byte     = r_snap[{r_digit, 3'b000} +: 8];
        w_an_on    = ~(8'b0000_0001 << r_digit);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_digit      <= '0;
            r_snap       <= '0;
            r_an_n       <= '1;
            r_seg_n      <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt   <= '0;
                r_digit <= r_digit + 3'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            // Snapshot reload coincides with a guard cycle, so no torn digit is ever shown.
            if (w_boundary && !hold) begin
                r_snap <= seg7_dot64;
            end
            r_frame_tick <= w_boundary && !hold;

            if (blank || w_guard) begin
                r_an_n  <= '1;
                r_seg_n <= '1;
            end else begin
                r_an_n  <= w_an_on;
                r_seg_n <= ~w_byte;
            end
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 64-bit debug dot vector `seg7_dot64`: 8 digits × 8 segments.
- Time-multiplexes the vector onto a common-anode 8-digit 7-segment display with active-low anodes and segments.
- Captures a tear-free snapshot once per scan frame.
- Inserts a blanking guard at every digit change to suppress ghosting.

Parameters:
- SCAN_DIV, 16'd50000, clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 16'd500, guard cycles at the start of each slot with all anodes off; legal range 1 to SCAN_DIV-1.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- seg7_dot64  input  64  dot vector; byte k = bits [8k+7:8k] drives digit k. Within a byte: bit0 = seg a … bit6 = seg g, bit7 = dp. 1 = lit.
- hold  input  1  1 = keep the current snapshot at frame boundaries (freeze display).
- blank  input  1  1 = force all anodes and segments off; scanning continues.
- an_n  output  8  digit anodes, active low; bit k = digit k.
- seg_n  output  8  segments, active low; same bit order as a seg7_dot64 byte.
- frame_tick  output  1  one-cycle pulse on each cycle the snapshot is reloaded.

Behaviour:
- Registers:
  - cnt: 16-bit slot counter.
  - digit: 3-bit digit index.
  - snap: 64-bit snapshot.
  - an_n, seg_n, frame_tick: output registers.
- Reset (synchronous; overrides everything, including mid-slot): cnt=0, digit=0, snap=0, an_n=8'hFF, seg_n=8'hFF, frame_tick=0.
- Counter:
  - Each non-reset cycle: if cnt == SCAN_DIV-1, then cnt←0 and digit←digit+1 (wraps 7→0). Otherwise cnt←cnt+1.
  - One frame = 8·SCAN_DIV cycles.
- Frame boundary: a cycle with digit==0 and cnt==0, including the first cycle after reset deasserts.
  - hold==0: snap←seg7_dot64 and frame_tick←1 on the next edge.
  - hold==1: snap unchanged and frame_tick←0.
  - frame_tick is 0 on all other cycles.
  - seg7_dot64 changes mid-frame never reach the display before the next boundary.
- Phases within a slot, decided from the current cnt:
  - GUARD: cnt < BLANK_CYCLES.
  - ON: cnt ≥ BLANK_CYCLES.
- Output registers, loaded each cycle from the current cnt, digit and snap (1-cycle latency):
  - blank==1 or GUARD: an_n←8'hFF, seg_n←8'hFF.
  - Otherwise (ON): an_n←~(8'b1<<digit), seg_n←~snap[8·digit+7 -: 8].
- Snapshot-to-output ordering:
  - At a boundary, snap updates on the same edge that registers the GUARD outputs.
  - The new snapshot first appears at output cycle BLANK_CYCLES+1 of digit 0.
- Invariants:
  - Exactly zero or one an_n bit is low at any time.
  - an_n and seg_n are both 8'hFF for at least BLANK_CYCLES consecutive cycles around every digit change.
- Changing hold or blank:
  - Both take effect on the next edge.
  - blank does not reset cnt or digit.
  - hold deasserting mid-frame waits for the next boundary.
- Simultaneous hold==0 at a boundary and a seg7_dot64 change on that cycle: the value sampled at that edge is captured.
- Parameter violations are caught by an elaboration-time check in simulation; synthesis behaviour for illegal values is undefined.

Test Plan:
- All scenarios use SCAN_DIV=4, BLANK_CYCLES=1.
1. Reset sequence: hold reset 3 cycles with seg7_dot64=64'h0123456789ABCDEF → an_n=8'hFF, seg_n=8'hFF, frame_tick=0 during reset. First cycle after release → frame_tick=1 one cycle later. Digit-0 ON cycles → an_n=8'hFE, seg_n=8'h10.
2. Full scan: continue from 1 → observe 8 slots of 4 cycles each (1 GUARD, 3 ON).
   - Digit 3: an_n=8'hF7, seg_n=~8'h89=8'h76.
   - Digit 7: an_n=8'h7F, seg_n=8'hFE.
   - Wrap back to digit 0 → frame_tick pulse every 32 cycles.
3. Tear-free update: change seg7_dot64 to 64'hFF00FF00FF00FF00 during digit 2 → digits 2–7 still show the old bytes. After the next boundary, digit 0 shows seg_n=8'hFF and digit 1 shows seg_n=8'h00.
4. Hold: assert hold across a boundary, then change the input → frame_tick stays 0 and the old pattern repeats. Release hold mid-frame → update occurs only at the next boundary.
5. Blank: assert blank for 10 cycles mid-slot → an_n=8'hFF and seg_n=8'hFF throughout. On release, the digit index matches free-running count (no restart).
6. Reset mid-frame: assert reset during digit 5 ON → next cycle an_n=8'hFF, seg_n=8'hFF, snap=0. After release, scan restarts at digit 0 and frame_tick pulses.
